// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bundle of the two requester ports and the data memory port of dmem_arbiter
interface dmem_arbiter_if;
  logic        req0_i;
  logic        req1_i;
  logic        we0_i;
  logic        we1_i;
  logic        lock0_i;
  logic        lock1_i;
  logic [31:0] addr0_i;
  logic [31:0] addr1_i;
  logic [31:0] wdata0_i;
  logic [31:0] wdata1_i;
  logic        gnt0_o;
  logic        gnt1_o;
  logic        rvalid0_o;
  logic        rvalid1_o;
  logic [31:0] rdata0_o;
  logic [31:0] rdata1_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req0_i, req1_i, we0_i, we1_i, lock0_i, lock1_i,
    input  addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o,
    output mem_addr_o, mem_wdata_o, mem_we_o
  );

  modport master (
    output req0_i, req1_i, we0_i, we1_i, lock0_i, lock1_i,
    output addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with lockable ownership and bounded lock length
// Build option DMEM_ARB_RR_EN: round-robin contention in IDLE; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  localparam logic [7:0] LOCK_MAX_C = LOCK_MAX[7:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        at_max;
  logic        arb;
  logic        pref0;
  logic        pref1;
  logic        gnt0_c;
  logic        gnt1_c;
  logic        gnt0;
  logic        gnt1;
  logic        rvalid0_q;
  logic        rvalid1_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
`ifdef DMEM_ARB_RR_EN
  logic        last_gnt_q;
`endif

  assign at_max = (cnt_q == LOCK_MAX_C);

  always_comb begin
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    arb     = 1'b0;
    pref0   = 1'b0;
    pref1   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      OWN0: begin
        if (bus.req0_i && bus.lock0_i && !at_max) begin
          gnt0_c = 1'b1;
          cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else begin
          arb   = 1'b1;
          // a forced release hands the cycle to the other port first
          pref1 = at_max;
        end
      end
      OWN1: begin
        if (bus.req1_i && bus.lock1_i && !at_max) begin
          gnt1_c = 1'b1;
          cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else begin
          arb   = 1'b1;
          pref0 = at_max;
        end
      end
      default: arb = 1'b1;
    endcase

    if (arb) begin
      if (pref1 && bus.req1_i) begin
        gnt1_c = 1'b1;
      end else if (pref0 && bus.req0_i) begin
        gnt0_c = 1'b1;
      end else if (bus.req0_i && bus.req1_i) begin
`ifdef DMEM_ARB_RR_EN
        gnt0_c = last_gnt_q;
        gnt1_c = !last_gnt_q;
`else
        gnt0_c = 1'b1;
`endif
      end else begin
        gnt0_c = bus.req0_i;
        gnt1_c = bus.req1_i;
      end

      if (gnt0_c && bus.lock0_i) begin
        state_d = OWN0;
        cnt_d   = 8'd1;
      end else if (gnt1_c && bus.lock1_i) begin
        state_d = OWN1;
        cnt_d   = 8'd1;
      end else begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    end
  end

  // no grant may escape while reset is held, even though grant is combinational
  assign gnt0 = gnt0_c & rst_n;
  assign gnt1 = gnt1_c & rst_n;

  assign bus.gnt0_o      = gnt0;
  assign bus.gnt1_o      = gnt1;
  assign bus.mem_addr_o  = gnt0 ? bus.addr0_i  : (gnt1 ? bus.addr1_i  : 32'd0);
  assign bus.mem_wdata_o = gnt0 ? bus.wdata0_i : (gnt1 ? bus.wdata1_i : 32'd0);
  assign bus.mem_we_o    = (gnt0 & bus.we0_i) | (gnt1 & bus.we1_i);

  assign bus.rvalid0_o   = rvalid0_q;
  assign bus.rvalid1_o   = rvalid1_q;
  assign bus.rdata0_o    = rdata0_q;
  assign bus.rdata1_o    = rdata1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_gnt_q <= gnt1;
    end
  end
`endif

  // read return path: data captured in the grant cycle, presented with a one-cycle valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      rvalid0_q <= gnt0 & !bus.we0_i;
      rvalid1_q <= gnt1 & !bus.we1_i;
      if (gnt0 && !bus.we0_i) begin
        rdata0_q <= bus.mem_rdata_i;
      end
      if (gnt1 && !bus.we1_i) begin
        rdata1_q <= bus.mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.LOCK_MAX(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_i = 0; bus.req1_i = 0; bus.we0_i = 0; bus.we1_i = 0;
    bus.lock0_i = 0; bus.lock1_i = 0;
    bus.addr0_i = 0; bus.addr1_i = 0; bus.wdata0_i = 0; bus.wdata1_i = 0;
    bus.mem_rdata_i = 0;
  endtask

  initial begin
    logic exp1;
    total  = 0;
    passed = 0;
    idle_inputs();
    rst_n = 1'b0;
    tick();

    // reset state, including a request presented while reset is held
    bus.req0_i = 1; bus.addr0_i = 32'h44;
    #1;
    chk("rst_gnt0", {31'd0, bus.gnt0_o}, 32'd0);
    chk("rst_gnt1", {31'd0, bus.gnt1_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_rvalid0", {31'd0, bus.rvalid0_o}, 32'd0);
    chk("rst_rvalid1", {31'd0, bus.rvalid1_o}, 32'd0);
    chk("rst_rdata0", bus.rdata0_o, 32'd0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    // read on port 0
    bus.req0_i = 1; bus.addr0_i = 32'h10; bus.mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("rd_gnt0", {31'd0, bus.gnt0_o}, 32'd1);
    chk("rd_gnt1", {31'd0, bus.gnt1_o}, 32'd0);
    chk("rd_mem_addr", bus.mem_addr_o, 32'h10);
    chk("rd_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
    tick();
    idle_inputs();
    chk("rd_rvalid0", {31'd0, bus.rvalid0_o}, 32'd1);
    chk("rd_rdata0", bus.rdata0_o, 32'hDEADBEEF);
    #1;
    chk("idle_mem_addr", bus.mem_addr_o, 32'd0);
    tick();
    chk("rd_rvalid0_pulse", {31'd0, bus.rvalid0_o}, 32'd0);
    chk("rd_rdata0_hold", bus.rdata0_o, 32'hDEADBEEF);

    // write on port 1
    bus.req1_i = 1; bus.we1_i = 1; bus.addr1_i = 32'h40; bus.wdata1_i = 32'h12345678;
    bus.mem_rdata_i = 32'h0BADF00D;
    #1;
    chk("wr_gnt1", {31'd0, bus.gnt1_o}, 32'd1);
    chk("wr_mem_we", {31'd0, bus.mem_we_o}, 32'd1);
    chk("wr_mem_wdata", bus.mem_wdata_o, 32'h12345678);
    chk("wr_mem_addr", bus.mem_addr_o, 32'h40);
    tick();
    idle_inputs();
    #1;
    chk("wr_rvalid1", {31'd0, bus.rvalid1_o}, 32'd0);
    chk("wr_rdata1", bus.rdata1_o, 32'd0);
    chk("wr_mem_we_after", {31'd0, bus.mem_we_o}, 32'd0);
    tick();

    // contention, back-to-back reads
    bus.req0_i = 1; bus.req1_i = 1;
    bus.addr0_i = 32'h100; bus.addr1_i = 32'h200;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp1 = i[0];
`else
      exp1 = 1'b0;
`endif
      bus.mem_rdata_i = 32'hA000_0000 + i;
      #1;
      chk($sformatf("cont_gnt0_%0d", i), {31'd0, bus.gnt0_o}, {31'd0, !exp1});
      chk($sformatf("cont_gnt1_%0d", i), {31'd0, bus.gnt1_o}, {31'd0, exp1});
      tick();
      if (exp1) begin
        chk($sformatf("cont_rdata1_%0d", i), bus.rdata1_o, 32'hA000_0000 + i);
        chk($sformatf("cont_rvalid1_%0d", i), {31'd0, bus.rvalid1_o}, 32'd1);
      end else begin
        chk($sformatf("cont_rdata0_%0d", i), bus.rdata0_o, 32'hA000_0000 + i);
        chk($sformatf("cont_rvalid0_%0d", i), {31'd0, bus.rvalid0_o}, 32'd1);
      end
    end
    idle_inputs();
    tick();

    // lock on port 1 bounded at 16 grants, then one forced cycle for port 0
    bus.req1_i = 1; bus.lock1_i = 1;
    #1;
    chk("lock_gnt1_0", {31'd0, bus.gnt1_o}, 32'd1);
    tick();
    bus.req0_i = 1;
    for (int i = 1; i < 16; i++) begin
      #1;
      chk($sformatf("lock_gnt1_%0d", i), {31'd0, bus.gnt1_o}, 32'd1);
      chk($sformatf("lock_gnt0_%0d", i), {31'd0, bus.gnt0_o}, 32'd0);
      tick();
    end
    #1;
    chk("lock_rel_gnt0", {31'd0, bus.gnt0_o}, 32'd1);
    chk("lock_rel_gnt1", {31'd0, bus.gnt1_o}, 32'd0);
    tick();
    bus.req0_i = 0;
    #1;
    chk("lock_resume_gnt1", {31'd0, bus.gnt1_o}, 32'd1);
    tick();
    idle_inputs();
    tick();

    // lock drop on port 0 while port 1 waits
    bus.req0_i = 1; bus.lock0_i = 1;
    #1;
    chk("own0_gnt0", {31'd0, bus.gnt0_o}, 32'd1);
    tick();
    bus.req1_i = 1;
    #1;
    chk("own0_deny1", {31'd0, bus.gnt1_o}, 32'd0);
    chk("own0_keep0", {31'd0, bus.gnt0_o}, 32'd1);
    tick();
    bus.lock0_i = 0;
    #1;
`ifdef DMEM_ARB_RR_EN
    chk("drop_gnt1", {31'd0, bus.gnt1_o}, 32'd1);
`else
    chk("drop_gnt0", {31'd0, bus.gnt0_o}, 32'd1);
`endif
    tick();
    idle_inputs();
    tick();

    // reset while a locked read on port 0 is in flight
    bus.req0_i = 1; bus.lock0_i = 1; bus.addr0_i = 32'h20; bus.mem_rdata_i = 32'hCAFEF00D;
    #1;
    chk("mrst_gnt0", {31'd0, bus.gnt0_o}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_gnt0_low", {31'd0, bus.gnt0_o}, 32'd0);
    chk("mrst_mem_addr", bus.mem_addr_o, 32'd0);
    tick();
    chk("mrst_rvalid0", {31'd0, bus.rvalid0_o}, 32'd0);
    chk("mrst_rdata0", bus.rdata0_o, 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    tick();
    chk("mrst_rvalid0_after", {31'd0, bus.rvalid0_o}, 32'd0);
    bus.req1_i = 1;
    #1;
    chk("mrst_idle_gnt1", {31'd0, bus.gnt1_o}, 32'd1);
    tick();
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 16, the maximum number of consecutive locked grants to one port before forced release (range 2..255).
REQ-002 SHALL have the following ports, one per entry:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req0_i / req1_i  in  1  access request; port 0 = core, port 1 = loader/debug
- we0_i / we1_i  in  1  write enable of the request
- lock0_i / lock1_i  in  1  request to keep ownership on following cycles
- addr0_i / addr1_i  in  32  byte address
- wdata0_i / wdata1_i  in  32  write data
- gnt0_o / gnt1_o  out  1  request accepted this cycle
- rvalid0_o / rvalid1_o  out  1  read data valid, one-cycle pulse
- rdata0_o / rdata1_o  out  32  read data
- mem_addr_o  out  32  address to data memory
- mem_wdata_o  out  32  write data to data memory
- mem_we_o  out  1  data memory write enable
- mem_rdata_i  in  32  combinational read data from data memory

Function
REQ-003 SHALL grant at most one port per cycle; gnt is combinational from the requests and the registered state.
REQ-004 SHALL drive mem_addr_o, mem_wdata_o, and mem_we_o from the granted port in the grant cycle; with no grant, all three SHALL be 0.
REQ-005 SHALL, on a granted read (we=0), register mem_rdata_i and pulse the matching rvalid for exactly one cycle on the next cycle.
REQ-006 SHALL leave rdata unchanged except when rvalid is asserted.
REQ-007 SHALL NOT assert rvalid for granted writes.
REQ-008 SHALL implement FSM states IDLE, OWN0, and OWN1.
REQ-009 SHALL transition IDLE->OWNn when port n is granted with lockn_i=1; otherwise it SHALL stay in IDLE.
REQ-010 In OWNn, SHALL grant only port n and SHALL deny the other port even when it requests.
REQ-011 In OWNn, SHALL return to IDLE when reqn_i=0 or lockn_i=0 (that cycle is arbitrated as IDLE) or when the lock counter reaches LOCK_MAX.
REQ-012 SHALL count locked grants in an 8-bit lock counter: cleared in IDLE, incremented per granted cycle in OWNn.
REQ-013 When the counter equals LOCK_MAX, SHALL force IDLE for one cycle, in which the other port wins if it requests.
REQ-014 The counter SHALL never wrap.
REQ-015 In IDLE with a single requester, SHALL grant that requester.
REQ-016 In IDLE with both requesting, SHALL resolve per REQ-022.
REQ-017 SHALL update last_gnt (1 bit) on every grant.
REQ-018 SHALL leave state, counter, and last_gnt unchanged on idle cycles with no request.
REQ-019 SHALL give priority to a read completing (rvalid) and a new grant in the same cycle simultaneously; no stall.

Reset
REQ-020 On rst_n=0 (asynchronous), SHALL clear state to IDLE, counter to 0, rvalid0/1 to 0, rdata0/1 to 0x00000000, and last_gnt to 1, so port 0 wins the first contention.
REQ-021 Reset during a pending read SHALL discard the read: no rvalid after release; gnt and mem outputs SHALL be 0 while rst_n=0.

Configuration
REQ-022 With macro DMEM_ARB_RR_EN defined, IDLE contention SHALL grant the port not in last_gnt (round-robin); without it, SHALL grant port 0 always (fixed priority) and last_gnt is unused.

Verification
REQ-023 Read: req0 with addr0=0x10, mem_rdata=0xDEADBEEF -> gnt0=1, mem_addr=0x10, mem_we=0; next cycle rvalid0=1, rdata0=0xDEADBEEF.
REQ-024 Contention: req0 and req1 both held for 4 cycles, RR build -> grants 0,1,0,1; fixed build -> 0,0,0,0.
REQ-025 Lock: req1+lock1 held for 20 cycles, req0 held, LOCK_MAX=16 -> gnt1 for 16 cycles, then gnt0 for 1 cycle, then port 1 resumes.
REQ-026 Write: req1, we1=1, addr1=0x40, wdata1=0x12345678 -> mem_we=1, mem_wdata=0x12345678 for 1 cycle; rvalid1 stays 0.
REQ-027 Reset mid-read: grant read on port 0, assert rst_n=0 before the next edge -> rvalid0 never pulses; state=IDLE, rdata0=0.
REQ-028 Lock drop: in OWN0, lock0 goes 0 while req1=1 -> same cycle arbitrated as IDLE; RR build grants port 1.
